// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch front end: reset vector,
// NOP encoding and the entry format buffered between fetch and decode.
package instr_fetch_queue_pkg;

  // Boot vector used when the top-level parameter is left at its default.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  // SLL $0,$0,0 -- what decode sees while the queue is empty.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // One buffered fetch result.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Small synchronous FIFO with occupancy count and synchronous clear.
// Used for the fetch buffer and for the in-order PC queue of in-flight
// requests. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against occupancy; a pop frees room for a same-cycle push.
  always_comb begin
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
  end

  // Storage, pointers and occupancy; clear empties the queue in one edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (clear) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wptr_r] <= wdata;
        wptr_r        <= wptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (do_pop_s && !do_push_s) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

  // Head and status views.
  always_comb begin
    rdata = mem_r[rptr_r];
    count = count_r;
    full  = (count_r == CW'(DEPTH));
    empty = (count_r == {CW{1'b0}});
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers returned
// instructions with their PCs, and hands them to decode. Redirects drop both
// buffered and in-flight instructions; misaligned PCs produce a single
// address-error entry and stop fetch until the next redirect.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        id_adel_o,
  input  logic        id_stall_i
);

  localparam int CW = $clog2(DEPTH + 1);

  // Fetch state
  logic [31:0]   pc_r;
  logic          req_held_r;
  logic          held_stale_r;
  logic [31:0]   req_addr_r;
  logic [CW-1:0] discard_r;
  logic          halted_r;
  logic          run_r;

  // Queue interfaces
  logic [FETCH_ENTRY_W-1:0] fifo_rdata_s;
  logic [CW-1:0]            fifo_count_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic                     fifo_push_s;
  fetch_entry_t             fifo_wentry_s;
  fetch_entry_t             head_s;
  logic [31:0]              pcq_head_s;
  logic [CW-1:0]            pcq_count_s;
  logic                     pcq_full_s;
  logic                     pcq_empty_s;

  // Per-cycle events
  logic          issue_s;
  logic          accept_s;
  logic          ret_s;
  logic          drop_s;
  logic          stale_accept_s;
  logic          pop_s;
  logic          push_data_s;
  logic          mis_s;
  logic [CW:0]   credit_sum_s;
  logic [CW-1:0] discard_next_s;
  logic [CW-1:0] discard_flush_s;

  // Request generation, response classification and next discard count.
  // Outstanding requests are exactly the PC-queue occupancy, so the credit
  // check bounds buffered plus in-flight entries by DEPTH.
  always_comb begin
    credit_sum_s = {1'b0, fifo_count_s} + {1'b0, pcq_count_s};
    issue_s      = run_r && !halted_r && (pc_r[1:0] == 2'b00) &&
                   (credit_sum_s < (CW + 1)'(DEPTH)) && !pcq_full_s;
    inst_req_o   = req_held_r || issue_s;
    if (req_held_r) begin
      inst_addr_o = req_addr_r;
    end else begin
      inst_addr_o = pc_r;
    end
    accept_s       = inst_req_o && inst_addr_ok_i;
    stale_accept_s = accept_s && held_stale_r;
    ret_s          = inst_data_ok_i && !pcq_empty_s;
    drop_s         = ret_s && (discard_r != {CW{1'b0}});
    pop_s          = id_valid_o && !id_stall_i;
    push_data_s    = ret_s && !drop_s && !flush_i;
    // Error entry only once nothing live is still in flight, so it lands
    // after every instruction fetched ahead of it.
    mis_s          = run_r && !halted_r && (pc_r[1:0] != 2'b00) &&
                     (pcq_count_s == discard_r) &&
                     (!fifo_full_s || pop_s) && !flush_i;
    discard_next_s  = discard_r - CW'(drop_s) + CW'(stale_accept_s);
    discard_flush_s = pcq_count_s + CW'(accept_s) - CW'(ret_s);
  end

  // Select what enters the fetch buffer: returned word or address-error marker.
  always_comb begin
    fifo_push_s = push_data_s || mis_s;
    if (mis_s) begin
      fifo_wentry_s.pc    = pc_r;
      fifo_wentry_s.instr = NOP_INSTR;
      fifo_wentry_s.adel  = 1'b1;
    end else begin
      fifo_wentry_s.pc    = pcq_head_s;
      fifo_wentry_s.instr = inst_rdata_i;
      fifo_wentry_s.adel  = 1'b0;
    end
  end

  // Decode-side view of the buffer head; zero (NOP) when empty.
  always_comb begin
    head_s     = fetch_entry_t'(fifo_rdata_s);
    id_valid_o = !fifo_empty_s;
    if (!fifo_empty_s) begin
      id_instr_o = head_s.instr;
      id_pc_o    = head_s.pc;
      id_adel_o  = head_s.adel;
    end else begin
      id_instr_o = NOP_INSTR;
      id_pc_o    = 32'h0000_0000;
      id_adel_o  = 1'b0;
    end
  end

  // Fetch PC, held-request tracking, discard accounting and halt state.
  // A request raised but not yet accepted keeps its address across a
  // redirect; if a redirect happened meanwhile it is marked stale and its
  // eventual response is discarded instead of advancing the PC.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_r         <= RESET_PC;
      req_held_r   <= 1'b0;
      held_stale_r <= 1'b0;
      req_addr_r   <= RESET_PC;
      discard_r    <= {CW{1'b0}};
      halted_r     <= 1'b0;
      run_r        <= 1'b0;
    end else begin
      run_r        <= 1'b1;
      req_held_r   <= inst_req_o && !inst_addr_ok_i;
      held_stale_r <= (flush_i || held_stale_r) && inst_req_o && !inst_addr_ok_i;
      req_addr_r   <= inst_addr_o;
      if (flush_i) begin
        pc_r      <= flush_pc_i;
        discard_r <= discard_flush_s;
        halted_r  <= 1'b0;
      end else begin
        if (accept_s && !stale_accept_s) begin
          pc_r <= next_fetch_pc(pc_r);
        end
        discard_r <= discard_next_s;
        if (mis_s) begin
          halted_r <= 1'b1;
        end
      end
    end
  end

  // Fetch buffer presented to decode; a redirect empties it.
  sync_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fetch_buf (
    .clk    (clk),
    .resetn (resetn),
    .clear  (flush_i),
    .push   (fifo_push_s),
    .pop    (pop_s),
    .wdata  (fifo_wentry_s),
    .rdata  (fifo_rdata_s),
    .count  (fifo_count_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

  // PC of every accepted request, popped as responses return in order.
  // Never cleared by a redirect: it must stay aligned with the memory.
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk    (clk),
    .resetn (resetn),
    .clear  (1'b0),
    .push   (accept_s),
    .pop    (ret_s),
    .wdata  (inst_addr_o),
    .rdata  (pcq_head_s),
    .count  (pcq_count_s),
    .full   (pcq_full_s),
    .empty  (pcq_empty_s)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue. A simple memory model accepts when
// enabled and returns ~addr as the instruction word, in order.
module tb_instr_fetch_queue;

  logic        clk;
  logic        resetn;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_adel_o;
  logic        id_stall_i;

  int checks;
  int errors;

  logic        accept_en;
  logic        resp_en;
  logic [31:0] mq[$];
  logic [31:0] popped_pc[$];
  logic [31:0] popped_instr[$];
  logic        popped_adel[$];
  int          req_seen;
  logic        last_acc;
  logic        last_dok;

  instr_fetch_queue dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush_i        (flush_i),
    .flush_pc_i     (flush_pc_i),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_addr_ok_i (inst_addr_ok_i),
    .inst_data_ok_i (inst_data_ok_i),
    .inst_rdata_i   (inst_rdata_i),
    .id_valid_o     (id_valid_o),
    .id_instr_o     (id_instr_o),
    .id_pc_o        (id_pc_o),
    .id_adel_o      (id_adel_o),
    .id_stall_i     (id_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One clock: drive memory handshake at negedge, sample, advance the model.
  task automatic cycle();
    logic [31:0] a;
    inst_addr_ok_i = accept_en && inst_req_o;
    if (resp_en && mq.size() > 0) begin
      inst_data_ok_i = 1'b1;
      inst_rdata_i   = ~mq[0];
    end else begin
      inst_data_ok_i = 1'b0;
      inst_rdata_i   = 32'h0;
    end
    #1;
    if (id_valid_o && !id_stall_i) begin
      popped_pc.push_back(id_pc_o);
      popped_instr.push_back(id_instr_o);
      popped_adel.push_back(id_adel_o);
    end
    if (inst_req_o) req_seen++;
    last_acc = inst_addr_ok_i;
    last_dok = inst_data_ok_i;
    a = inst_addr_o;
    @(posedge clk);
    if (last_dok) void'(mq.pop_front());
    if (last_acc) mq.push_back(a);
    @(negedge clk);
  endtask

  task automatic clear_pops();
    popped_pc.delete();
    popped_instr.delete();
    popped_adel.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    flush_i = 1'b0; flush_pc_i = 32'h0; id_stall_i = 1'b0;
    accept_en = 1'b0; resp_en = 1'b0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = 32'h0;
    mq.delete();
    clear_pops();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", inst_req_o); end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", id_valid_o); end
    checks++; if (id_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", id_instr_o); end
    checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", id_pc_o); end
    checks++; if (id_adel_o !== 1'b0) begin errors++; $display("FAIL reset_adel: got %b expected 0", id_adel_o); end
    apply_reset();
  endtask

  task automatic test_sequential();
    logic early;
    early = 1'b0;
    apply_reset();
    accept_en = 1'b1; resp_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_dok) break;
      if (id_valid_o) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL seq_early_valid: got %b expected 0", early); end
    checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL seq_latency_valid: got %b expected 1", id_valid_o); end
    checks++; if (id_pc_o !== 32'hBFC0_0000) begin errors++; $display("FAIL seq_first_pc: got %h expected bfc00000", id_pc_o); end
    repeat (6) cycle();
    checks++; if (popped_pc.size() < 3) begin errors++; $display("FAIL seq_count: got %0d expected >=3", popped_pc.size()); end
    else begin
      checks++; if (popped_pc[0] !== 32'hBFC0_0000) begin errors++; $display("FAIL seq_pc0: got %h expected bfc00000", popped_pc[0]); end
      checks++; if (popped_pc[1] !== 32'hBFC0_0004) begin errors++; $display("FAIL seq_pc1: got %h expected bfc00004", popped_pc[1]); end
      checks++; if (popped_pc[2] !== 32'hBFC0_0008) begin errors++; $display("FAIL seq_pc2: got %h expected bfc00008", popped_pc[2]); end
      checks++; if (popped_instr[0] !== 32'h403F_FFFF) begin errors++; $display("FAIL seq_instr0: got %h expected 403fffff", popped_instr[0]); end
      checks++; if (popped_instr[2] !== 32'h403F_FFF7) begin errors++; $display("FAIL seq_instr2: got %h expected 403ffff7", popped_instr[2]); end
    end
  endtask

  task automatic test_stall();
    int acc_cnt;
    acc_cnt = 0;
    apply_reset();
    id_stall_i = 1'b1; accept_en = 1'b1; resp_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_acc) acc_cnt++;
    end
    checks++; if (acc_cnt !== 4) begin errors++; $display("FAIL stall_accepts: got %0d expected 4", acc_cnt); end
    checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", inst_req_o); end
    checks++; if (id_pc_o !== 32'hBFC0_0000) begin errors++; $display("FAIL stall_head: got %h expected bfc00000", id_pc_o); end
    id_stall_i = 1'b0;
    clear_pops();
    repeat (12) cycle();
    checks++; if (popped_pc.size() < 5) begin errors++; $display("FAIL stall_drain_count: got %0d expected >=5", popped_pc.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (popped_pc[i] !== 32'hBFC0_0000 + 32'(4 * i)) begin
          errors++; $display("FAIL stall_drain_pc%0d: got %h expected %h", i, popped_pc[i], 32'hBFC0_0000 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_flush();
    int acc_cnt;
    acc_cnt = 0;
    apply_reset();
    accept_en = 1'b1; resp_en = 1'b0;
    for (int i = 0; i < 10 && acc_cnt < 3; i++) begin
      cycle();
      if (last_acc) acc_cnt++;
    end
    checks++; if (acc_cnt !== 3) begin errors++; $display("FAIL flush_setup: got %0d expected 3", acc_cnt); end
    flush_i = 1'b1; flush_pc_i = 32'h8000_0100;
    cycle();
    flush_i = 1'b0;
    clear_pops();
    resp_en = 1'b1;
    repeat (20) cycle();
    checks++; if (popped_pc.size() < 2) begin errors++; $display("FAIL flush_count: got %0d expected >=2", popped_pc.size()); end
    else begin
      checks++; if (popped_pc[0] !== 32'h8000_0100) begin errors++; $display("FAIL flush_pc0: got %h expected 80000100", popped_pc[0]); end
      checks++; if (popped_instr[0] !== 32'h7FFF_FEFF) begin errors++; $display("FAIL flush_instr0: got %h expected 7ffffeff", popped_instr[0]); end
      checks++; if (popped_pc[1] !== 32'h8000_0104) begin errors++; $display("FAIL flush_pc1: got %h expected 80000104", popped_pc[1]); end
    end
  endtask

  task automatic test_misaligned();
    apply_reset();
    accept_en = 1'b1; resp_en = 1'b1;
    cycle();
    flush_i = 1'b1; flush_pc_i = 32'h8000_0102;
    cycle();
    flush_i = 1'b0;
    clear_pops();
    req_seen = 0;
    repeat (8) cycle();
    checks++; if (req_seen !== 0) begin errors++; $display("FAIL mis_no_req: got %0d expected 0", req_seen); end
    checks++; if (popped_pc.size() !== 1) begin errors++; $display("FAIL mis_entries: got %0d expected 1", popped_pc.size()); end
    else begin
      checks++; if (popped_pc[0] !== 32'h8000_0102) begin errors++; $display("FAIL mis_pc: got %h expected 80000102", popped_pc[0]); end
      checks++; if (popped_instr[0] !== 32'h0) begin errors++; $display("FAIL mis_instr: got %h expected 0", popped_instr[0]); end
      checks++; if (popped_adel[0] !== 1'b1) begin errors++; $display("FAIL mis_adel: got %b expected 1", popped_adel[0]); end
    end
    flush_i = 1'b1; flush_pc_i = 32'h8000_0200;
    cycle();
    flush_i = 1'b0;
    clear_pops();
    repeat (10) cycle();
    checks++; if (popped_pc.size() < 1) begin errors++; $display("FAIL mis_resume_count: got %0d expected >=1", popped_pc.size()); end
    else begin
      checks++; if (popped_pc[0] !== 32'h8000_0200) begin errors++; $display("FAIL mis_resume_pc: got %h expected 80000200", popped_pc[0]); end
      checks++; if (popped_adel[0] !== 1'b0) begin errors++; $display("FAIL mis_resume_adel: got %b expected 0", popped_adel[0]); end
    end
  endtask

  task automatic test_flush_with_data();
    apply_reset();
    accept_en = 1'b1; resp_en = 1'b0;
    cycle();
    cycle();
    accept_en = 1'b0; resp_en = 1'b1;
    flush_i = 1'b1; flush_pc_i = 32'h8000_0300;
    cycle();
    flush_i = 1'b0;
    checks++; if (inst_req_o !== 1'b1) begin errors++; $display("FAIL held_req: got %b expected 1", inst_req_o); end
    checks++; if (inst_addr_o !== 32'hBFC0_0004) begin errors++; $display("FAIL held_addr: got %h expected bfc00004", inst_addr_o); end
    accept_en = 1'b1;
    clear_pops();
    repeat (15) cycle();
    checks++; if (popped_pc.size() < 1) begin errors++; $display("FAIL fwd_count: got %0d expected >=1", popped_pc.size()); end
    else begin
      checks++; if (popped_pc[0] !== 32'h8000_0300) begin errors++; $display("FAIL fwd_pc0: got %h expected 80000300", popped_pc[0]); end
      checks++; if (popped_instr[0] !== 32'h7FFF_FCFF) begin errors++; $display("FAIL fwd_instr0: got %h expected 7ffffcff", popped_instr[0]); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    id_stall_i = 1'b1; accept_en = 1'b1; resp_en = 1'b0;
    cycle();
    cycle();
    resp_en = 1'b1;
    cycle();
    resp_en = 1'b0;
    cycle();
    checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", id_valid_o); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL ar_req: got %b expected 0", inst_req_o); end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", id_valid_o); end
    checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL ar_pc: got %h expected 0", id_pc_o); end
    checks++; if (id_instr_o !== 32'h0) begin errors++; $display("FAIL ar_instr: got %h expected 0", id_instr_o); end
    mq.delete();
    clear_pops();
    id_stall_i = 1'b0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    accept_en = 1'b1; resp_en = 1'b1;
    repeat (10) cycle();
    checks++; if (popped_pc.size() < 1) begin errors++; $display("FAIL ar_restart_count: got %0d expected >=1", popped_pc.size()); end
    else begin
      checks++; if (popped_pc[0] !== 32'hBFC0_0000) begin errors++; $display("FAIL ar_restart_pc: got %h expected bfc00000", popped_pc[0]); end
      checks++; if (popped_instr[0] !== 32'h403F_FFFF) begin errors++; $display("FAIL ar_restart_instr: got %h expected 403fffff", popped_instr[0]); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; req_seen = 0;
    last_acc = 1'b0; last_dok = 1'b0;
    resetn = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0; id_stall_i = 1'b0;
    accept_en = 1'b0; resp_en = 1'b0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_misaligned();
    test_flush_with_data();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Front-end producer for the decode stage. Generates sequential fetch PCs and issues requests on the SRAM-like instruction-memory interface.
- Buffers returned words with their PCs in a small FIFO and presents them to decode via the id_instr/id_stall interface.
- Handles pipeline redirects (branch/exception flush), including discarding responses already in flight, and tags misaligned fetch PCs.

Parameters:
- DEPTH, 4, FIFO entries; also the maximum number of outstanding requests (power of 2, ≥2).
- RESET_PC, 32'hBFC0_0000, first fetch PC after reset.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- flush_i  in  1  redirect: drop all buffered and in-flight instructions.
- flush_pc_i  in  32  new fetch PC, valid while flush_i is high.
- inst_req_o  out  1  request valid.
- inst_addr_o  out  32  request word address.
- inst_addr_ok_i  in  1  request accepted this cycle.
- inst_data_ok_i  in  1  read data valid this cycle; responses return in order.
- inst_rdata_i  in  32  read data.
- id_valid_o  out  1  FIFO head valid.
- id_instr_o  out  32  head instruction; 32'h0 (NOP) when empty.
- id_pc_o  out  32  head PC; 0 when empty.
- id_adel_o  out  1  head entry carries a fetch address error.
- id_stall_i  in  1  decode not consuming; head is held.

Behaviour:
- Reset (async, resetn=0):
  - pc=RESET_PC; FIFO empty; outstanding=0; discard=0; halted=0.
  - All outputs 0: inst_req_o, id_valid_o, id_instr_o, id_pc_o, id_adel_o.
- State: pc, req_held, count (0..DEPTH), outstanding (0..DEPTH), discard (0..DEPTH), halted, FIFO of {pc, instr, adel}.
- Issue:
  - inst_req_o=1 when !halted and pc[1:0]==0 and (req_held or count+outstanding<DEPTH).
  - outstanding counts accepted requests not yet returned.
  - inst_addr_o=pc.
- Stable-request rule: once inst_req_o rises, inst_addr_o stays constant and req stays high until inst_addr_ok_i, even across a flush.
- Accept: on inst_addr_ok_i, outstanding+1 and pc+=4 (wraps mod 2^32); req_held clears.
- Response: on inst_data_ok_i, outstanding−1.
  - If discard>0: discard−1 and the data is dropped.
  - Otherwise push {pc_of_request, inst_rdata_i, 0}.
  - The PC of each request is tracked in a DEPTH-entry in-order PC queue, or equivalently stored at accept into the reserved FIFO slot.
- Pop: when id_valid_o && !id_stall_i, at the rising edge. Push and pop in the same cycle are legal. Credits guarantee no overflow, so a push into a full FIFO is an assertion failure.
- Latency: a response pushed at edge N is visible on id_* after edge N (registered FIFO, no bypass).
- Misaligned pc (pc[1:0]≠0, !halted):
  - No memory request is issued.
  - Once every non-discarded in-flight response has returned, push {pc, 32'h0, adel=1} and set halted=1.
  - Fetching stays stopped until flush_i.
- Flush (flush_i=1 at an edge):
  - FIFO cleared; halted=0; pc=flush_pc_i.
  - discard = outstanding + (inst_addr_ok_i ? 1 : 0) − (inst_data_ok_i ? 1 : 0) + discard_adjust. The rule is that every request accepted before or at the flush edge has its response dropped.
  - A held, unaccepted request keeps its old address. When accepted, it is counted into discard rather than advancing pc.
  - inst_data_ok_i in the flush cycle is dropped.
  - A pop in the flush cycle is still consumed by decode; the flush has priority over the FIFO contents.
- Simultaneous events: a flush overrides push, pop and the misaligned insert. Reset overrides everything.
- Output encoding when empty: id_instr_o=0 so the decoder sees SLL $0 (NOP).

Decomposition:
- Shared package/header, next to the existing defines:
  - RESET_PC constant.
  - NOP encoding 32'h0.
  - fetch-entry struct {pc[31:0], instr[31:0], adel}.
- One natural sub-module: sync_fifo (parameterised width/depth; count, push/pop, clear). It also serves as the in-order PC queue.

Test Plan:
- Reset release, memory accepts every cycle with 1-cycle data → PCs BFC00000, BFC00004, BFC00008 presented in order; id_instr_o equals the returned words.
- id_stall_i=1 for 10 cycles → exactly DEPTH=4 requests accepted, then inst_req_o=0. After stall release, entries pop one per cycle and fetch resumes.
- Three requests in flight, flush_i with flush_pc_i=80000100 → the three old responses are dropped; the next id_pc_o is 80000100.
- Flush to 80000102 → no inst_req_o; one entry {pc=80000102, instr=0, adel=1}; no further requests until a flush to 80000200.
- inst_data_ok_i and flush_i in the same cycle, plus a held request accepted after the flush → both responses are discarded; no stale PC reaches id_*.
- Async resetn pulse mid-burst with outstanding=2 → all outputs 0 immediately; fetch restarts at BFC00000 with a clean FIFO.
